// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-requester (CPU / front panel) arbiter and sequencer for the single
// 4096 x 12-bit memory bus. Grants round-robin, holds the granted
// transaction on the bus until the memory finishes (or a watchdog expires),
// then returns data with a one-cycle done pulse to the winner.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  // CPU requester
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_rtype,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [11:0] cpu_rdata,
  // Front-panel requester
  input  logic        pnl_req,
  input  logic        pnl_we,
  input  logic        pnl_rtype,
  input  logic [11:0] pnl_addr,
  input  logic [11:0] pnl_wdata,
  output logic        pnl_done,
  output logic        pnl_err,
  output logic [11:0] pnl_rdata,
  // Memory side
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_read_type,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  input  logic [11:0] mem_read_data,
  input  logic        mem_finished,
  // Status
  output logic        busy,
  output logic        owner
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;
  logic             any_req;
  logic             grant;
  logic             grant_pnl;
  logic             timeout;
  logic             issue_end;

  assign any_req   = cpu_req | pnl_req;
  assign grant     = (state == IDLE) && any_req;
  // Under contention the requester that did not win last time goes first.
  assign grant_pnl = pnl_req & (~cpu_req | ~last_grant);
  assign timeout   = (cnt == LAST_CNT);
  // A finishing memory beats a simultaneous watchdog expiry.
  assign issue_end = (state == ISSUE) && (mem_finished || timeout);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (any_req)   state_next = ISSUE;
      ISSUE:   if (issue_end) state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Latch the winner's transaction at grant; held for the whole of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      lat_we         <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read_type  <= 1'b0;
    end else if (grant) begin
      owner          <= grant_pnl;
      last_grant     <= grant_pnl;
      lat_we         <= grant_pnl ? pnl_we    : cpu_we;
      mem_address    <= grant_pnl ? pnl_addr  : cpu_addr;
      mem_write_data <= grant_pnl ? pnl_wdata : cpu_wdata;
      mem_read_type  <= grant_pnl ? pnl_rtype : cpu_rtype;
    end
  end

  // Memory strobes: raised at grant, dropped on leaving ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else if (grant) begin
      mem_read_enable  <= grant_pnl ? ~pnl_we : ~cpu_we;
      mem_write_enable <= grant_pnl ?  pnl_we :  cpu_we;
    end else if (issue_end) begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end
  end

  // Watchdog: counts ISSUE cycles since grant, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (grant)                     cnt <= '0;
    else if (state == ISSUE && !timeout) cnt <= cnt + 1'b1;
  end

  // Completion: one-cycle done/err to the winner, read data captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      pnl_done  <= 1'b0;
      pnl_err   <= 1'b0;
      pnl_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      pnl_done <= 1'b0;
      pnl_err  <= 1'b0;
      if (issue_end) begin
        if (owner) begin
          pnl_done <= 1'b1;
          pnl_err  <= ~mem_finished;
          if (mem_finished && !lat_we) pnl_rdata <= mem_read_data;
        end else begin
          cpu_done <= 1'b1;
          cpu_err  <= ~mem_finished;
          if (mem_finished && !lat_we) cpu_rdata <= mem_read_data;
        end
      end
    end
  end

endmodule
